shuffle_unit: RTL and testbench
===============================

SHUFFLE_UNIT -- requirements
Module: shuffle_unit

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50000000, clock frequency used to derive the 1 ms tick.
REQ-002 SHALL have parameter SEED, default 16'hACE1, LFSR reset value; a value of 0 SHALL be replaced by 16'hACE1.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port shuffleFlag, input, 1, shuffle request level.
REQ-006 SHALL have port loadFlag, output, 1, high while shuffled cards are being presented or held.
REQ-007 SHALL have port card, output, 6, current card index 0..51.
REQ-008 SHALL have port time_ms, output, 32, milliseconds elapsed since reset.

Function
REQ-009 SHALL hold a 52-entry deck of 6-bit card indices, initialised to identity (deck[k]=k).
REQ-010 SHALL run a 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1, advancing every cycle in every state.
REQ-011 SHALL implement FSM states IDLE, SHUFFLE, LOAD, DONE.
REQ-012 IDLE: loadFlag=0; shuffleFlag sampled 1 -> SHUFFLE next cycle, index i=51.
REQ-013 SHUFFLE: Fisher-Yates; candidate j=LFSR[5:0]; if j<=i swap deck[i],deck[j] in that cycle and decrement i, else retry next cycle; after swap at i=1 -> LOAD.
REQ-014 LOAD: loadFlag=1; card=deck[k] for k=0..51, one card per cycle; after k=51 -> DONE.
REQ-015 DONE: loadFlag=1, card holds deck[51]; shuffleFlag=0 -> IDLE, else stay.
REQ-016 shuffleFlag deassertion during SHUFFLE or LOAD SHALL NOT abort the operation; only reset aborts.
REQ-017 A new shuffle SHALL start from the current deck permutation, not from identity.
REQ-018 The 52 cards presented in LOAD SHALL be a permutation of 0..51 (no duplicates, none missing).
REQ-019 card SHALL be 0 in IDLE before the first LOAD; after a LOAD it holds deck[51] in all states.
REQ-020 Millisecond timer: CYCLES_PER_MS=CLK_FREQ_HZ/1000 (minimum 1); cycle counter wraps from CYCLES_PER_MS-1 to 0 and time_ms increments on that wrap.
REQ-021 time_ms SHALL wrap from 32'hFFFFFFFF to 0 without any flag.
REQ-022 Timer SHALL run independently of FSM state.

Reset
REQ-023 rst=0 at a clock edge SHALL force: state IDLE, loadFlag=0, card=0, time_ms=0, cycle counter=0, deck=identity, LFSR=SEED, i=51.
REQ-024 Reset mid-SHUFFLE or mid-LOAD SHALL discard the partial permutation.

Configuration
REQ-025 Macro MILLIS_EN: defined -> timer per REQ-020..022; undefined -> no timer logic, time_ms tied to 0.

Verification
REQ-026 Reset with rst=0 for 2 cycles -> loadFlag=0, card=0, time_ms=0, state IDLE.
REQ-027 MILLIS_EN defined, CLK_FREQ_HZ=4000 -> time_ms reads 1,2,3 after 4,8,12 cycles following reset release.
REQ-028 shuffleFlag=1 held -> loadFlag rises, 52 consecutive card values form a permutation of 0..51, then loadFlag stays 1 with card constant until shuffleFlag=0, then loadFlag=0 next cycle.
REQ-029 Same SEED, two runs -> identical 52-card sequence; SEED=16'h1234 vs default -> sequences differ.
REQ-030 rst=0 during SHUFFLE -> IDLE, loadFlag=0; a new request yields the same sequence as the first run after reset.
REQ-031 MILLIS_EN undefined, 10000 cycles -> time_ms=0 throughout.

Source files
------------

// File: rtl/shuffle_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------
// | shuffle_unit : LFSR-driven Fisher-Yates deck shuffler with card presenter
// | Optional millisecond timer enabled by macro MILLIS_EN.
// | Revision: 1.0  initial release
// +----------------------------------------------------------------------------
module shuffle_unit #(
  parameter int          CLK_FREQ_HZ = 50000000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shuffleFlag,
  output logic        loadFlag,
  output logic [5:0]  card,
  output logic [31:0] time_ms
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] TAP_MASK = 16'hB400;
  localparam logic [5:0]  LAST_IDX = 6'd51;
  localparam int          DECK_N   = 52;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHUFFLE = 2'd1,
    LOAD    = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [5:0]  deck [0:DECK_N-1];
  logic [5:0]  idx_i;
  logic [5:0]  idx_k;
  logic [5:0]  cand_j;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAP_MASK : 16'h0000);
  assign cand_j    = lfsr[5:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      loadFlag <= 1'b0;
      card     <= 6'd0;
      lfsr     <= SEED_EFF;
      idx_i    <= LAST_IDX;
      idx_k    <= 6'd0;
      for (int n = 0; n < DECK_N; n++) begin
        deck[n] <= 6'(n);
      end
    end else begin
      lfsr <= lfsr_next;
      case (state)
        IDLE: begin
          loadFlag <= 1'b0;
          if (shuffleFlag) begin
            state <= SHUFFLE;
            idx_i <= LAST_IDX;
          end
        end
        SHUFFLE: begin
          loadFlag <= 1'b0;
          // Out-of-range candidates are rejected and retried with the next LFSR value.
          if (cand_j <= idx_i) begin
            deck[idx_i]  <= deck[cand_j];
            deck[cand_j] <= deck[idx_i];
            if (idx_i == 6'd1) begin
              state <= LOAD;
              idx_k <= 6'd0;
            end else begin
              idx_i <= idx_i - 6'd1;
            end
          end
        end
        LOAD: begin
          loadFlag <= 1'b1;
          card     <= deck[idx_k];
          if (idx_k == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx_k <= idx_k + 6'd1;
          end
        end
        DONE: begin
          loadFlag <= 1'b1;
          if (!shuffleFlag) begin
            state    <= IDLE;
            loadFlag <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          loadFlag <= 1'b0;
        end
      endcase
    end
  end

`ifdef MILLIS_EN
  localparam int CYCLES_PER_MS = ((CLK_FREQ_HZ / 1000) < 1) ? 1 : (CLK_FREQ_HZ / 1000);
  localparam logic [31:0] CNT_LAST = 32'(CYCLES_PER_MS - 1);

  logic [31:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_cnt <= 32'd0;
      time_ms <= 32'd0;
    end else if (cyc_cnt == CNT_LAST) begin
      cyc_cnt <= 32'd0;
      time_ms <= time_ms + 32'd1;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`else
  assign time_ms = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shuffle_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_shuffle_unit : directed bench for shuffle_unit (three seeds in parallel)
// | Revision: 1.0  initial release
// +----------------------------------------------------------------------------
module tb_shuffle_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        shuffleFlag = 1'b0;
  logic [2:0]  load_v;
  logic [17:0] card_v;
  logic [95:0] tms_v;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shuffle_unit #(.CLK_FREQ_HZ(4000)) dut0 (
    .clk(clk), .rst(rst), .shuffleFlag(shuffleFlag),
    .loadFlag(load_v[0]), .card(card_v[5:0]), .time_ms(tms_v[31:0]));
  shuffle_unit #(.CLK_FREQ_HZ(4000), .SEED(16'h1234)) dut1 (
    .clk(clk), .rst(rst), .shuffleFlag(shuffleFlag),
    .loadFlag(load_v[1]), .card(card_v[11:6]), .time_ms(tms_v[63:32]));
  shuffle_unit #(.CLK_FREQ_HZ(4000), .SEED(16'h0000)) dut2 (
    .clk(clk), .rst(rst), .shuffleFlag(shuffleFlag),
    .loadFlag(load_v[2]), .card(card_v[17:12]), .time_ms(tms_v[95:64]));

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSRs: seed ACE1 (dut0, dut2) and seed 1234 (dut1).
  logic [15:0] m_lfsr [2];
  always @(posedge clk) begin
    if (!rst) begin
      m_lfsr[0] <= 16'hACE1;
      m_lfsr[1] <= 16'h1234;
    end else begin
      m_lfsr[0] <= lfsr_next(m_lfsr[0]);
      m_lfsr[1] <= lfsr_next(m_lfsr[1]);
    end
  end

  // Captures the first 52 cards of every loadFlag window, per instance.
  int cap [3][52];
  int cidx [3];
  int done_cnt [3];
  always @(negedge clk) begin
    for (int x = 0; x < 3; x++) begin
      if (load_v[x]) begin
        if (cidx[x] < 52) begin
          cap[x][cidx[x]] <= int'(card_v[6*x +: 6]);
          cidx[x]         <= cidx[x] + 1;
          if (cidx[x] == 51) done_cnt[x] <= done_cnt[x] + 1;
        end
      end else begin
        cidx[x] <= 0;
      end
    end
  end

  int m_deck [2][52];
  int run1 [52];

  task automatic model_reset();
    for (int x = 0; x < 2; x++)
      for (int k = 0; k < 52; k++) m_deck[x][k] = k;
  endtask

  task automatic model_shuffle(input int sel, input logic [15:0] l0, output int s);
    int i, j, t;
    logic [15:0] l;
    i = 51; l = l0; s = 0;
    while (i >= 1 && s < 100000) begin
      j = int'(l[5:0]);
      if (j <= i) begin
        t = m_deck[sel][i]; m_deck[sel][i] = m_deck[sel][j]; m_deck[sel][j] = t;
        i--;
      end
      l = lfsr_next(l);
      s++;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    shuffleFlag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
  endtask

  // Requests a shuffle and waits for all three instances to present 52 cards.
  task automatic run_shuffle(input bit hold, output int lat, output bit tmo,
                             output logic [15:0] l0a, output logic [15:0] l0b);
    int base [3];
    int g;
    for (int x = 0; x < 3; x++) base[x] = done_cnt[x];
    @(negedge clk);
    shuffleFlag = 1'b1;
    @(posedge clk);
    #1;
    l0a = m_lfsr[0];
    l0b = m_lfsr[1];
    if (!hold) begin
      @(negedge clk);
      shuffleFlag = 1'b0;
    end
    lat = 0;
    while (!load_v[0] && lat < 20000) begin
      @(posedge clk); #1; lat++;
    end
    g = 0;
    while ((done_cnt[0] == base[0] || done_cnt[1] == base[1] || done_cnt[2] == base[2]) && g < 20000) begin
      @(posedge clk); #1; g++;
    end
    tmo = (lat >= 20000) || (g >= 20000);
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (load_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset_load got=%0b exp=0", load_v[0]); end
    n_cmp++; if (card_v[5:0] !== 6'd0) begin n_fail++; $display("FAIL reset_card got=%0d exp=0", card_v[5:0]); end
    n_cmp++; if (tms_v[31:0] !== 32'd0) begin n_fail++; $display("FAIL reset_time got=%0d exp=0", tms_v[31:0]); end
    n_cmp++; if (load_v[2:1] !== 2'b00) begin n_fail++; $display("FAIL reset_load_others got=%b exp=00", load_v[2:1]); end
  endtask

  task automatic test_timer_start();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
`ifdef MILLIS_EN
      n_cmp++;
      if (tms_v[31:0] !== 32'(n / 4)) begin
        n_fail++; $display("FAIL timer_cycle%0d got=%0d exp=%0d", n, tms_v[31:0], n / 4);
      end
`else
      n_cmp++;
      if (load_v[0] !== 1'b0 || card_v[5:0] !== 6'd0 || tms_v[31:0] !== 32'd0) begin
        n_fail++; $display("FAIL idle_cycle%0d got load=%0b card=%0d time=%0d exp 0/0/0", n, load_v[0], card_v[5:0], tms_v[31:0]);
      end
`endif
    end
  endtask

  task automatic check_perm(input int x, input string tag);
    bit [51:0] seen;
    int bad;
    seen = '0; bad = 0;
    for (int k = 0; k < 52; k++) begin
      if (cap[x][k] < 0 || cap[x][k] > 51) bad++;
      else if (seen[cap[x][k]]) bad++;
      else seen[cap[x][k]] = 1'b1;
    end
    n_cmp++;
    if (bad !== 0) begin n_fail++; $display("FAIL %s_perm got=%0d bad_entries exp=0", tag, bad); end
  endtask

  task automatic check_model(input int x, input int sel, input string tag);
    int bad, first;
    bad = 0; first = -1;
    for (int k = 0; k < 52; k++)
      if (cap[x][k] !== m_deck[sel][k]) begin bad++; if (first < 0) first = k; end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL %s_seq got=%0d diffs (card[%0d]=%0d exp=%0d) exp=0", tag, bad, first, cap[x][first], m_deck[sel][first]);
    end
  endtask

  task automatic test_shuffle_hold();
    int lat, sa, sb, diff;
    bit tmo;
    logic [15:0] la, lb;
    run_shuffle(1'b1, lat, tmo, la, lb);
    model_shuffle(0, la, sa);
    model_shuffle(1, lb, sb);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL hold_timeout got=1 exp=0"); end
    n_cmp++; if (lat !== sa + 1) begin n_fail++; $display("FAIL hold_latency got=%0d exp=%0d", lat, sa + 1); end
    check_perm(0, "hold");
    check_model(0, 0, "hold_seedACE1");
    check_model(1, 1, "hold_seed1234");
    check_model(2, 0, "hold_seed0");
    diff = 0;
    for (int k = 0; k < 52; k++) if (cap[1][k] != cap[0][k]) diff++;
    n_cmp++; if (diff == 0) begin n_fail++; $display("FAIL seed_differs got=0 differing cards exp>0"); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (load_v[0] !== 1'b1 || int'(card_v[5:0]) !== m_deck[0][51]) begin
        n_fail++; $display("FAIL done_hold%0d got load=%0b card=%0d exp load=1 card=%0d", c, load_v[0], card_v[5:0], m_deck[0][51]);
      end
    end
    @(negedge clk);
    shuffleFlag = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (load_v !== 3'b000) begin n_fail++; $display("FAIL done_release got=%b exp=000", load_v); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (int'(card_v[5:0]) !== m_deck[0][51]) begin
      n_fail++; $display("FAIL idle_card_hold got=%0d exp=%0d", card_v[5:0], m_deck[0][51]);
    end
    for (int k = 0; k < 52; k++) run1[k] = cap[0][k];
  endtask

  task automatic test_pulse_continue();
    int lat, sa, sb;
    bit tmo;
    logic [15:0] la, lb;
    run_shuffle(1'b0, lat, tmo, la, lb);
    model_shuffle(0, la, sa);
    model_shuffle(1, lb, sb);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL pulse_timeout got=1 exp=0"); end
    n_cmp++; if (lat !== sa + 1) begin n_fail++; $display("FAIL pulse_latency got=%0d exp=%0d", lat, sa + 1); end
    check_perm(0, "pulse");
    check_model(0, 0, "pulse_seedACE1");
    check_model(1, 1, "pulse_seed1234");
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (load_v !== 3'b000) begin n_fail++; $display("FAIL pulse_end_load got=%b exp=000", load_v); end
  endtask

  task automatic test_reset_mid_shuffle();
    int lat, sa, sb, bad;
    bit tmo;
    logic [15:0] la, lb;
    apply_reset();
    n_cmp++; if (card_v[5:0] !== 6'd0) begin n_fail++; $display("FAIL rst_card got=%0d exp=0", card_v[5:0]); end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    shuffleFlag = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (load_v[0] !== 1'b0) begin n_fail++; $display("FAIL mid_shuffle_load got=%0b exp=0", load_v[0]); end
    apply_reset();
    n_cmp++; if (load_v[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst_load got=%0b exp=0", load_v[0]); end
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(posedge clk);
    run_shuffle(1'b1, lat, tmo, la, lb);
    model_shuffle(0, la, sa);
    model_shuffle(1, lb, sb);
    n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rerun_timeout got=1 exp=0"); end
    check_model(0, 0, "rerun_seedACE1");
    bad = 0;
    for (int k = 0; k < 52; k++) if (cap[0][k] !== run1[k]) bad++;
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL rerun_repeat got=%0d diffs exp=0", bad); end
    @(negedge clk);
    shuffleFlag = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_timer_long();
`ifdef MILLIS_EN
    apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (400) @(posedge clk);
    #1;
    n_cmp++; if (tms_v[31:0] !== 32'd100) begin n_fail++; $display("FAIL timer_400 got=%0d exp=100", tms_v[31:0]); end
`else
    int bad;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk); #1;
      if (tms_v !== 96'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL no_timer got=%0d nonzero samples exp=0", bad); end
`endif
  endtask

  initial begin
    for (int x = 0; x < 3; x++) begin cidx[x] = 0; done_cnt[x] = 0; end
    model_reset();
    test_reset();
    test_timer_start();
    test_shuffle_hold();
    test_pulse_continue();
    test_reset_mid_shuffle();
    test_timer_long();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
